// File: rtl/uf7_add_seq.sv
// Multi-cycle adder for the 7-bit unsigned mini-float (exp[6:4], man[3:0], value 1.man x 2^exp).
// Aligns the smaller operand one bit per cycle, then adds, normalises, rounds half-up and saturates.
module uf7_add_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] a,
  input  logic [EXP_W+MAN_W-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] c,
  output logic                   ovf
);

  localparam int OP_W  = EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 2;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIG_W);

  typedef enum logic [1:0] {IDLE, ALIGN, NORM, DONE} state_t;

  state_t             state, state_n;
  logic [EXP_W-1:0]   ex;
  logic [SIG_W-1:0]   sx, sy;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic [EXP_W-1:0]   exp_a, exp_b, diff;
  logic               swap;
  logic [CNT_W-1:0]   cnt_init;

  logic [SIG_W:0]     sum;
  logic [EXP_W:0]     e_pre, e_fin;
  logic [MAN_W-1:0]   m_pre;
  logic               r;
  logic [MAN_W:0]     m_rnd;
  logic               ovf_n;
  logic [OP_W-1:0]    c_n;

  assign exp_a  = a[OP_W-1:MAN_W];
  assign exp_b  = b[OP_W-1:MAN_W];
  // Ties keep a as X, so equal exponents never swap.
  assign swap   = exp_b > exp_a;
  assign diff   = swap ? exp_b - exp_a : exp_a - exp_b;
  assign accept = in_valid & in_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_init = CNT_W'(diff);
    if (32'(diff) > SIG_W) cnt_init = CNT_MAX;
  end

  always_comb begin
    sum   = {1'b0, sx} + {1'b0, sy};
    e_pre = {1'b0, ex} + {{EXP_W{1'b0}}, sum[SIG_W]};
    if (sum[SIG_W]) begin
      m_pre = sum[SIG_W-1:2];
      r     = sum[1];
    end else begin
      m_pre = sum[SIG_W-2:1];
      r     = sum[0];
    end
    // A mantissa wrap from rounding carries into the exponent.
    m_rnd = {1'b0, m_pre} + {{MAN_W{1'b0}}, r};
    e_fin = e_pre + {{EXP_W{1'b0}}, m_rnd[MAN_W]};
    ovf_n = e_fin[EXP_W];
    c_n   = ovf_n ? '1 : {e_fin[EXP_W-1:0], m_rnd[MAN_W-1:0]};
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_n = ALIGN;
      end
      ALIGN: if (cnt == '0) state_n = NORM;
      NORM:  state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex  <= '0;
      sx  <= '0;
      sy  <= '0;
      cnt <= '0;
      c   <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ex  <= swap ? exp_b : exp_a;
          sx  <= {1'b1, (swap ? b[MAN_W-1:0] : a[MAN_W-1:0]), 1'b0};
          sy  <= {1'b1, (swap ? a[MAN_W-1:0] : b[MAN_W-1:0]), 1'b0};
          cnt <= cnt_init;
        end
        ALIGN: if (cnt != '0) begin
          sy  <= sy >> 1;
          cnt <= cnt - CNT_W'(1);
        end
        NORM: begin
          c   <= c_n;
          ovf <= ovf_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uf7_add_seq.sv
// Directed bench for uf7_add_seq: hand-computed sums, latencies, handshake stall and mid-op reset.
module tb_uf7_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] a = '0;
  logic [6:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] c;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  uf7_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands and complete the accept edge; inputs are then scrambled.
  task automatic start(input logic [6:0] pa, input logic [6:0] pb, input string tag);
    @(negedge clk);
    a = pa;
    b = pb;
    in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 7'($urandom);
    b = 7'($urandom);
  endtask

  // Count edges from the accept edge until out_valid rises (bounded).
  task automatic collect(input logic [6:0] exp_c, input logic exp_ovf, input int exp_lat,
                         input string tag);
    int n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      a = 7'($urandom);
      b = 7'($urandom);
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " c"}, c, exp_c);
    check({tag, " ovf"}, ovf, exp_ovf);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid cleared"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [6:0] pa, input logic [6:0] pb, input logic [6:0] exp_c,
                        input logic exp_ovf, input int exp_lat, input string tag);
    start(pa, pb, tag);
    collect(exp_c, exp_ovf, exp_lat, tag);
    release_result(tag);
  endtask

  initial begin
    int seen;

    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset c", c, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(7'b1000001, 7'b1001000, 7'b1010101, 1'b0, 2, "eq_exp");
    run_op(7'b1000000, 7'b1001000, 7'b1010100, 1'b0, 2, "eq_exp2");
    run_op(7'b0110000, 7'b0011000, 7'b0110110, 1'b0, 4, "diff2");
    run_op(7'b0011000, 7'b0110000, 7'b0110110, 1'b0, 4, "diff2_swap");
    run_op(7'b0100000, 7'b0011111, 7'b0110000, 1'b0, 3, "round_carry");
    run_op(7'b1111000, 7'b1111000, 7'b1111111, 1'b1, 2, "ovf_sum");
    run_op(7'b1111111, 7'b1111111, 7'b1111111, 1'b1, 2, "ovf_max");
    run_op(7'b1110000, 7'b0000000, 7'b1110000, 1'b0, 8, "shift_cap");
    run_op(7'b0000000, 7'b1110000, 7'b1110000, 1'b0, 8, "shift_cap_swap");

    // Stall the consumer with a new request pending; result must hold and nothing is accepted.
    start(7'b0110000, 7'b0011000, "stall");
    collect(7'b0110110, 1'b0, 4, "stall");
    @(negedge clk);
    a = 7'b0100000;
    b = 7'b0011111;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall c", c, 7'b0110110);
      check("stall ovf", ovf, 0);
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall release out_valid", out_valid, 0);
    check("stall release in_ready", in_ready, 1);
    // in_valid is still high, so the waiting request is taken on the next edge.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    check("b2b accepted", in_ready, 0);
    collect(7'b0110000, 1'b0, 3, "b2b");
    release_result("b2b");

    // Abort during alignment (diff 3).
    start(7'b1000000, 7'b0011000, "abort");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort c", c, 0);
    check("abort ovf", ovf, 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort no stale result", seen, 0);
    run_op(7'b0110000, 7'b0011000, 7'b0110110, 1'b0, 4, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
